// File: rtl/j_txer2.sv
// j_txer2: buffered UART transmitter (start / DW data LSB-first / optional parity / 1-2 stop).
// Define J_TXER2_FIFO_EN for a DEPTH-entry TX FIFO; otherwise a single holding register is used.
module j_txer2 #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic [DW-1:0] din,
    input  logic          u2dwr,
    input  logic          paren,
    input  logic          even,
    input  logic          stop2,
    input  logic          bx16,
    input  logic          txpol,
    input  logic          txbrk,
    output logic          serout,
    output logic          tbe,
    output logic          tfull,
    output logic [CW-1:0] tcount,
    output logic          tidle,
    output logic          ovf
);

    localparam int unsigned BW = $clog2(DW + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          r_state;
    logic [3:0]      r_tick;
    logic [BW-1:0]   r_bitcnt;
    logic [DW-1:0]   r_shift;
    logic            r_paren;
    logic            r_stop2;
    logic            r_parbit;
    logic            r_line;
    logic            r_ovf;

    logic            w_empty;
    logic            w_full;
    logic [DW-1:0]   w_head;
    logic            w_start;
    logic            w_pop;
    logic            w_push;
    logic            w_bit_end;

    assign w_start   = (r_state == StIdle) & bx16 & ~w_empty & ~txbrk;
    assign w_pop     = w_start;
    // A full buffer still accepts a write when the head is leaving in the same cycle.
    assign w_push    = u2dwr & (~w_full | w_pop);
    assign w_bit_end = bx16 & (r_tick == 4'hf);

`ifdef J_TXER2_FIFO_EN
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_head  = r_mem[r_rptr];
    assign tcount  = r_count;

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end
`else
    logic [DW-1:0] r_hold;
    logic          r_hvalid;

    assign w_empty = ~r_hvalid;
    assign w_full  = r_hvalid;
    assign w_head  = r_hold;
    assign tcount  = CW'(r_hvalid);

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_hold   <= '0;
            r_hvalid <= 1'b0;
        end else if (w_push) begin
            r_hold   <= din;
            r_hvalid <= 1'b1;
        end else if (w_pop) begin
            r_hvalid <= 1'b0;
        end
    end
`endif

    // Line level is registered from the state being entered, so it lands the cycle after the edge.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_state  <= StIdle;
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_paren  <= 1'b0;
            r_stop2  <= 1'b0;
            r_parbit <= 1'b0;
            r_line   <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= u2dwr & ~w_push;
            if (bx16 && r_state != StIdle) r_tick <= r_tick + 4'd1;
            case (r_state)
                StIdle: begin
                    r_line <= 1'b1;
                    if (w_start) begin
                        r_state  <= StStart;
                        r_shift  <= w_head;
                        r_paren  <= paren;
                        r_stop2  <= stop2;
                        r_parbit <= even ? ^w_head : ~^w_head;
                        r_tick   <= '0;
                        r_bitcnt <= '0;
                        r_line   <= 1'b0;
                    end
                end
                StStart: begin
                    r_line <= 1'b0;
                    if (w_bit_end) begin
                        r_state <= StData;
                        r_line  <= r_shift[0];
                    end
                end
                StData: begin
                    r_line <= r_shift[0];
                    if (w_bit_end) begin
                        if (r_bitcnt == BW'(DW - 1)) begin
                            r_bitcnt <= '0;
                            if (r_paren) begin
                                r_state <= StParity;
                                r_line  <= r_parbit;
                            end else begin
                                r_state <= StStop;
                                r_line  <= 1'b1;
                            end
                        end else begin
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt + BW'(1);
                            r_line   <= r_shift[1];
                        end
                    end
                end
                StParity: begin
                    r_line <= r_parbit;
                    if (w_bit_end) begin
                        r_state <= StStop;
                        r_line  <= 1'b1;
                    end
                end
                StStop: begin
                    r_line <= 1'b1;
                    if (w_bit_end) begin
                        if (r_stop2 && r_bitcnt == '0) begin
                            r_bitcnt <= BW'(1);
                        end else begin
                            r_bitcnt <= '0;
                            r_state  <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Break masks the line only; the frame timing above keeps running.
            if (txbrk) r_line <= 1'b0;
        end
    end

    assign serout = r_line ^ txpol;
    assign tbe    = w_empty;
    assign tfull  = w_full;
    assign tidle  = w_empty & (r_state == StIdle);
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_j_txer2.sv
// Scoreboard bench for j_txer2: stimulus queues expected frames, a monitor samples serout mid-bit.
module tb_j_txer2;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef J_TXER2_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic          sys_clk = 1'b0;
    logic          resetl  = 1'b0;
    logic [DW-1:0] din;
    logic          u2dwr, paren, even, stop2, bx16, txpol, txbrk;
    logic          serout, tbe, tfull, tidle, ovf;
    logic [CW-1:0] tcount;

    int total = 0;
    int bad   = 0;
    logic [31:0] q_bits[$];
    int          q_n[$];
    int          bx_period = 0;
    logic        bx_force  = 1'b0;
    bit          mon_en    = 1'b0;

    j_txer2 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .resetl(resetl), .din(din), .u2dwr(u2dwr), .paren(paren),
        .even(even), .stop2(stop2), .bx16(bx16), .txpol(txpol), .txbrk(txbrk),
        .serout(serout), .tbe(tbe), .tfull(tfull), .tcount(tcount), .tidle(tidle), .ovf(ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    // Expected frame under the current paren/stop2 settings; parity bit is supplied by the caller.
    task automatic push_frame(input logic [DW-1:0] w, input logic par);
        logic [31:0] b;
        int n;
        b = '0;
        for (int i = 0; i < DW; i++) b[1+i] = w[i];
        n = DW + 1;
        if (paren) begin b[n] = par; n++; end
        b[n] = 1'b1; n++;
        if (stop2) begin b[n] = 1'b1; n++; end
        q_bits.push_back(b);
        q_n.push_back(n);
    endtask

    task automatic write(input logic [DW-1:0] w);
        din = w; u2dwr = 1'b1;
        cyc();
        u2dwr = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while (!tidle && c < maxc) begin cyc(); c++; end
        chk("idle_reached", tidle, 1);
    endtask

    task automatic run_frame(input logic [DW-1:0] w, input logic par, input int exp_ticks);
        int c, cnt;
        push_frame(w, par);
        write(w);
        c = 0;
        while (!tbe && c < 1000) begin cyc(); c++; end
        cnt = 0; c = 0;
        while (!tidle && c < 5000) begin
            cyc(); c++;
            if (bx16) cnt++;
        end
        chk("frame_ticks", cnt, exp_ticks);
    endtask

    // bx16 generator: updated at +3 after each edge so the stimulus (+2) and monitor (+1) are stable.
    initial begin
        int bx_cnt;
        bx_cnt = 0;
        bx16 = 1'b0;
        forever begin
            @(posedge sys_clk);
            #3;
            if (bx_period == 0) begin
                bx16 = bx_force;
            end else begin
                bx_cnt++;
                if (bx_cnt >= bx_period) bx_cnt = 0;
                bx16 = (bx_cnt == 0);
            end
        end
    end

    // Monitor: a low line from idle starts a frame; bit k is sampled 16k+8 ticks after the pop.
    initial begin
        int ticks, k, en;
        bit active, skip;
        logic [31:0] eb;
        active = 0; skip = 0; ticks = 0; k = 0; en = 0; eb = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!mon_en || !resetl) begin
                active = 0; skip = 0;
            end else if (skip) begin
                if (serout === 1'b1) skip = 0;
            end else if (!active) begin
                if (serout === 1'b0) begin
                    if (q_n.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame: unexpected start bit with nothing queued at %0t", $time);
                        skip = 1;
                    end else begin
                        active = 1; ticks = 0; k = 0; eb = q_bits[0]; en = q_n[0];
                    end
                end
            end else if (bx16) begin
                ticks++;
                if (ticks == 16 * k + 8) begin
                    chk("serout_bit", serout, eb[k]);
                    k++;
                    if (k == en) begin
                        void'(q_bits.pop_front());
                        void'(q_n.pop_front());
                        active = 0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ovf, brk_bad, c;
        logic [DW-1:0] w;
        din = '0; u2dwr = 0; paren = 0; even = 0; stop2 = 0; txpol = 0; txbrk = 0;
        bx_period = 1;
        n_ovf = 0; brk_bad = 0;

        repeat (3) cyc();
        chk("rst_serout", serout, 1);
        chk("rst_tbe", tbe, 1);
        chk("rst_tidle", tidle, 1);
        chk("rst_tcount", tcount, 0);
        chk("rst_tfull", tfull, 0);
        chk("rst_ovf", ovf, 0);
        resetl = 1'b1;
        repeat (3) cyc();
        chk("idle_serout", serout, 1);
        chk("idle_tidle", tidle, 1);
        txpol = 1'b1; #1;
        chk("idle_serout_pol", serout, 0);
        txpol = 1'b0; #1;
        chk("idle_serout_nopol", serout, 1);

        mon_en = 1;
        bx_period = 4;
        run_frame(8'hA5, 1'b0, 160);
        paren = 1; even = 1;
        run_frame(8'h07, 1'b1, 176);
        even = 0;
        run_frame(8'h07, 1'b0, 176);
        stop2 = 1;
        run_frame(8'h07, 1'b0, 192);
        paren = 0; stop2 = 0;

        // Overflow: no ticks, so nothing drains while five words are written.
        bx_period = 0; bx_force = 0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            w = 8'((i + 1) * 17);
            if (i < CAP) push_frame(w, 1'b0);
            din = w; u2dwr = 1'b1;
            cyc();
            chk("ovf_tcount", tcount, (i + 1 < CAP) ? i + 1 : CAP);
            chk("ovf_pulse", ovf, (i >= CAP) ? 1 : 0);
            if (ovf) n_ovf++;
        end
        u2dwr = 0;
        cyc();
        chk("ovf_clear", ovf, 0);
        chk("full_tfull", tfull, 1);
        chk("full_tcount", tcount, CAP);
        chk("ovf_count", n_ovf, 5 - CAP);

        // Write on the same cycle as the popping tick while full.
        push_frame(8'h66, 1'b0);
        din = 8'h66; u2dwr = 1'b1; bx_force = 1'b1;
        cyc();
        u2dwr = 0; bx_force = 0;
        chk("popwr_tcount", tcount, CAP);
        chk("popwr_ovf", ovf, 0);
        chk("popwr_tfull", tfull, 1);
        bx_period = 1;
        wait_idle(4000);
        c = 0;
        while (q_n.size() != 0 && c < 200) begin cyc(); c++; end
        chk("drain_queue", q_n.size(), 0);

        // Break mid-frame.
        mon_en = 0;
        write(8'hFF);
        repeat (40) cyc();
        chk("pre_brk_serout", serout, 1);
        txbrk = 1'b1;
        write(8'hFF);
        chk("brk_serout", serout, 0);
        for (int i = 0; i < 250; i++) begin
            cyc();
            if (serout !== 1'b0) brk_bad++;
        end
        chk("brk_hold_low", brk_bad, 0);
        chk("brk_no_start", tcount, 1);
        txbrk = 1'b0;
        cyc();
        chk("brk_release_pop", tcount, 0);
        chk("brk_release_start", serout, 0);
        wait_idle(1000);

        // Reset mid-DATA.
        write(8'h00);
        write(8'h00);
        chk("pre_rst_tcount", tcount, 1);
        repeat (24) cyc();
        chk("pre_rst_serout", serout, 0);
        resetl = 1'b0; #1;
        chk("rst_mid_serout", serout, 1);
        chk("rst_mid_tbe", tbe, 1);
        chk("rst_mid_tcount", tcount, 0);
        cyc();
        resetl = 1'b1;
        cyc();
        chk("rst_mid_tidle", tidle, 1);

        mon_en = 1;
        bx_period = 4;
        run_frame(8'h3C, 1'b0, 160);
        c = 0;
        while (q_n.size() != 0 && c < 200) begin cyc(); c++; end
        chk("final_queue", q_n.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
